prom_reader: RTL and testbench

- Sequential read initiator for the 512x8 bipolar PROM parts (74S472 class).
- Drives PROM address and active-low chip enable, waits a programmable access time, and captures each byte.
- Streams the captured bytes out over a valid/ready handshake and accumulates an 8-bit checksum.
- Used for boot-time PROM dumping/verification and for loading PROM images into RAM shadows.

---
 rtl/prom_reader.sv | 128 ++++++++++++
 tb/tb_prom_reader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prom_reader.sv
// Sequential reader for 512x8 bipolar PROMs: strobes CE_N, waits the
// access time, streams each byte over valid/ready and keeps a checksum.
module prom_reader #(
  parameter int ADDR_WIDTH  = 9,
  parameter int DATA_WIDTH  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   count,
  output logic [ADDR_WIDTH-1:0] prom_a,
  output logic                  prom_ce_n,
  input  logic [DATA_WIDTH-1:0] prom_d,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] checksum
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_WAIT,
    S_PRESENT,
    S_FINISH
  } state_t;

  localparam logic [3:0]            WLOAD   = 4'(WAIT_CYCLES - 1);
  localparam logic [ADDR_WIDTH:0]   ONE_R   = 1;
  localparam logic [ADDR_WIDTH-1:0] ONE_A   = 1;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH:0]     remain_q, remain_d;
  logic [3:0]              wcnt_q, wcnt_d;
  logic [ADDR_WIDTH-1:0]   prom_a_d;
  logic                    ce_n_d;
  logic [DATA_WIDTH-1:0]   data_d;
  logic                    valid_d;
  logic [DATA_WIDTH-1:0]   sum_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      remain_q  <= '0;
      wcnt_q    <= '0;
      prom_a    <= '0;
      prom_ce_n <= 1'b1;
      out_data  <= '0;
      out_valid <= 1'b0;
      checksum  <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      remain_q  <= remain_d;
      wcnt_q    <= wcnt_d;
      prom_a    <= prom_a_d;
      prom_ce_n <= ce_n_d;
      out_data  <= data_d;
      out_valid <= valid_d;
      checksum  <= sum_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    wcnt_d   = wcnt_q;
    prom_a_d = prom_a;
    ce_n_d   = prom_ce_n;
    data_d   = out_data;
    valid_d  = out_valid;
    sum_d    = checksum;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d   = base_addr;
          remain_d = count;
          sum_d    = '0;
          state_d  = (count == '0) ? S_FINISH : S_SETUP;
        end
      end
      S_SETUP: begin
        busy     = 1'b1;
        prom_a_d = addr_q;
        ce_n_d   = 1'b0;
        wcnt_d   = WLOAD;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (wcnt_q == '0) begin
          data_d  = prom_d;
          sum_d   = checksum + prom_d;
          valid_d = 1'b1;
          ce_n_d  = 1'b1;
          state_d = S_PRESENT;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      S_PRESENT: begin
        busy = 1'b1;
        if (out_ready) begin
          valid_d  = 1'b0;
          remain_d = remain_q - ONE_R;
          // address wraps naturally at 2^ADDR_WIDTH
          addr_d   = addr_q + ONE_A;
          state_d  = (remain_q == ONE_R) ? S_FINISH : S_SETUP;
        end
      end
      S_FINISH: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_prom_reader.sv
// Scoreboard bench for prom_reader: PROM model with access time,
// reference byte/address/checksum queues built from the run request.
module tb_prom_reader;
  localparam int AW = 9;
  localparam int DW = 8;
  localparam int W = 2;
  localparam int DEPTH = 512;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0] count = '0;
  logic [AW-1:0] prom_a;
  logic prom_ce_n;
  logic [DW-1:0] prom_d;
  logic [DW-1:0] out_data;
  logic out_valid;
  logic out_ready = 1'b1;
  logic busy;
  logic done;
  logic [DW-1:0] checksum;

  prom_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .base_addr(base_addr), .count(count),
    .prom_a(prom_a), .prom_ce_n(prom_ce_n), .prom_d(prom_d),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // PROM model: data valid only after W-1 full cycles with CE low
  logic [7:0] mem [DEPTH];
  int ce_cnt = 0;
  logic [7:0] junk = 8'h00;
  always @(posedge clk) begin
    junk <= 8'($urandom);
    if (!prom_ce_n) ce_cnt <= ce_cnt + 1;
    else ce_cnt <= 0;
  end
  assign prom_d = (!prom_ce_n && ce_cnt >= W - 1) ? mem[prom_a] : junk;

  int rdy_mode = 0;
  logic force_ready = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) out_ready = 1'b1;
    else if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
    else out_ready = force_ready;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  logic [7:0] exp_q[$];
  int addr_q[$];
  logic [7:0] exp_sum = 8'h00;
  int done_cnt = 0;
  int hs_count = 0;

  logic prev_ce_n = 1'b1;
  logic prev_valid = 1'b0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  int ce_fall = 0;
  int last_hs = 0;
  bit hs_pending = 0;

  always @(negedge clk) begin
    if (reset) begin
      prev_ce_n = 1'b1;
      prev_valid = 1'b0;
      prev_stall = 1'b0;
      hs_pending = 0;
    end else begin
      if (!prom_ce_n && prev_ce_n) begin
        if (addr_q.size() == 0) check("unexpected_read", 1, 0);
        else check("prom_a", 32'(prom_a), 32'(addr_q.pop_front()));
        if (hs_pending) check("setup_after_hs", cyc - last_hs, 2);
        hs_pending = 0;
        ce_fall = cyc;
      end
      if (out_valid && !prev_valid) begin
        check("latency", cyc - ce_fall, W);
        check("ce_in_present", 32'(prom_ce_n), 1);
      end
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 1);
        check("hold_data", 32'(out_data), 32'(prev_data));
        check("hold_ce", 32'(prom_ce_n), 1);
      end
      if (!busy && !prom_ce_n) check("ce_while_idle", 32'(prom_ce_n), 1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_byte", 1, 0);
        else check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        last_hs = cyc;
        hs_pending = 1;
        hs_count++;
      end
      if (done) begin
        check("done_busy", 32'(busy), 0);
        check("checksum", 32'(checksum), 32'(exp_sum));
        check("bytes_left", exp_q.size(), 0);
        done_cnt++;
        hs_pending = 0;
      end
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
      prev_ce_n = prom_ce_n;
      prev_valid = out_valid;
    end
  end

  task automatic start_run(input int b, input int n, output int d0);
    int k;
    k = 0;
    while ((busy || done) && k < 20000) begin
      @(posedge clk);
      k++;
    end
    if (k >= 20000) check("idle_timeout", 1, 0);
    @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = AW'(b);
    count = (AW + 1)'(n);
    exp_sum = 8'h00;
    for (int i = 0; i < n; i++) begin
      int a;
      a = (b + i) % DEPTH;
      addr_q.push_back(a);
      exp_q.push_back(mem[a]);
      exp_sum = exp_sum + mem[a];
    end
    d0 = done_cnt;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("busy_after_start", 32'(busy), (n != 0) ? 1 : 0);
    check("done_after_start", 32'(done), (n == 0) ? 1 : 0);
  endtask

  task automatic finish_run(input int d0);
    int k;
    k = 0;
    while (done_cnt == d0 && k < 20000) begin
      @(posedge clk);
      k++;
    end
    repeat (3) @(posedge clk);
    check("done_pulses", done_cnt - d0, 1);
  endtask

  task automatic run(input int b, input int n);
    int d0;
    start_run(b, n, d0);
    finish_run(d0);
  endtask

  initial begin
    int d0;
    int h0;
    int k;
    for (int a = 0; a < DEPTH; a++) mem[a] = 8'(a) ^ 8'h5A;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_prom_a", 32'(prom_a), 0);
    check("rst_ce_n", 32'(prom_ce_n), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_checksum", 32'(checksum), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    run(0, 4);

    for (int a = 0; a < DEPTH; a++) mem[a] = 8'(a);
    run(510, 4);

    run(0, 0);
    check("zero_checksum", 32'(checksum), 0);

    mem[0] = 8'h3C;
    @(negedge clk);
    force_ready = 1'b0;
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    start_run(0, 2, d0);
    k = 0;
    while (!out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    for (int i = 0; i < 10; i++) begin
      check("stall_valid", 32'(out_valid), 1);
      check("stall_data", 32'(out_data), 32'h3C);
      check("stall_ce_n", 32'(prom_ce_n), 1);
      @(negedge clk);
    end
    force_ready = 1'b1;
    finish_run(d0);

    rdy_mode = 1;
    for (int a = 0; a < DEPTH; a++) mem[a] = 8'($urandom);
    h0 = hs_count;
    start_run(7, 512, d0);
    repeat (100) @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = 9'd3;
    count = 10'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    finish_run(d0);
    check("hs_512", hs_count - h0, 512);

    for (int r = 0; r < 12; r++) begin
      for (int a = 0; a < DEPTH; a++) mem[a] = 8'($urandom);
      rdy_mode = $urandom_range(0, 1);
      run($urandom_range(0, DEPTH - 1),
          ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40));
    end

    rdy_mode = 0;
    start_run(0, 8, d0);
    k = 0;
    while (!(hs_count - h0 >= 512 + 0 && 1'b0) && k < 200) begin
      @(posedge clk);
      #1;
      k++;
      if (done_cnt == d0 && !prom_ce_n && exp_q.size() == 6) break;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    addr_q.delete();
    h0 = done_cnt;
    @(negedge clk);
    check("mid_rst_prom_a", 32'(prom_a), 0);
    check("mid_rst_ce_n", 32'(prom_ce_n), 1);
    check("mid_rst_out_data", 32'(out_data), 0);
    check("mid_rst_out_valid", 32'(out_valid), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_checksum", 32'(checksum), 0);
    repeat (6) @(posedge clk);
    check("no_done_after_rst", done_cnt - h0, 0);
    run(0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "watchdog");
  end
endmodule
